instruction_fetch_queue: RTL and testbench

//  Parametrised IF stage for the 5-stage RV32 pipeline; successor to the single-cycle fetch unit.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instruction_fetch_queue.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants for the instruction fetch queue slice:
//                default datapath width, default reset PC, the canonical
//                RV32 NOP (addi x0,x0,0) and the sequential PC increment.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          PC_STEP          = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous prefetch FIFO, DEPTH x WIDTH, with flush.
//                Head entry is presented combinationally on popData.
//                Push and pop in the same cycle are allowed even when full.
//  Ports       : clk, rst (async, active-low)
//                push/pushData   - write an entry
//                pop/popData     - consume head entry / head entry value
//                flush           - discard all entries (wins over push/pop)
//                full/empty/count- occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign popData = r_mem[r_rdPtr];

    assign w_doPop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_doPush = push && (!full || w_doPop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_doPush && !flush) r_mem[r_wrPtr] <= pushData;
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_queue
//  Description : IF stage for the 5-stage RV32 pipeline. Issues fetch
//                requests over a valid/ready interface, buffers returned
//                words in a prefetch FIFO and feeds decode via IF/ID regs.
//                Handles decode stall, EX redirect and stale-response discard.
//  Ports       : clk, rst (async, active-low)
//                PCSrcE, PCTargetE       - redirect from EX
//                StallD                  - hold IF/ID registers
//                ImemReqValid/Ready/Addr - request channel
//                ImemRspValid/Data       - in-order response channel
//                InstrD, PCD, PCPlus4D, ValidD - IF/ID outputs
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            ImemReqValid,
    input  logic            ImemReqReady,
    output logic [XLEN-1:0] ImemReqAddr,
    input  logic            ImemRspValid,
    input  logic [XLEN-1:0] ImemRspData,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int              CW     = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] c_nop  = XLEN'(NOP_INSTR);
    localparam logic [XLEN-1:0] c_step = XLEN'(PC_STEP);

    logic [XLEN-1:0]   r_fetchPc;
    logic [XLEN-1:0]   r_rspPc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_discard;
    logic [XLEN-1:0]   r_instrD;
    logic [XLEN-1:0]   r_pcD;
    logic [XLEN-1:0]   r_pcPlus4D;
    logic              r_validD;

    logic [XLEN-1:0]   w_target;
    logic [CW:0]       w_used;
    logic              w_reqFire;
    logic              w_rspIn;
    logic              w_keep;
    logic              w_pop;
    logic              w_fifoFull;
    logic              w_fifoEmpty;
    logic [CW-1:0]     w_fifoCount;
    logic [2*XLEN-1:0] w_popEntry;
    logic [XLEN-1:0]   w_popInstr;
    logic [XLEN-1:0]   w_popPc;

    // Redirect targets are always word aligned.
    assign w_target = PCTargetE & ~XLEN'(3);

    // Credits cover both buffered words and words still in flight, so a
    // returning response always finds a free FIFO slot.
    assign w_used       = {1'b0, w_fifoCount} + {1'b0, r_outstanding};
    assign ImemReqValid = rst && !PCSrcE && !w_fifoFull && (w_used < (CW+1)'(DEPTH));
    assign ImemReqAddr  = r_fetchPc;
    assign w_reqFire    = ImemReqValid && ImemReqReady;

    // Guarded so a spurious response can never underflow the counter.
    assign w_rspIn = ImemRspValid && (r_outstanding != '0);
    assign w_keep  = ImemRspValid && !PCSrcE && (r_discard == '0);
    assign w_pop   = !PCSrcE && !StallD && !w_fifoEmpty;

    assign w_popInstr = w_popEntry[2*XLEN-1:XLEN];
    assign w_popPc    = w_popEntry[XLEN-1:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_keep),
        .pushData ({ImemRspData, r_rspPc}),
        .pop      (w_pop),
        .popData  (w_popEntry),
        .flush    (PCSrcE),
        .full     (w_fifoFull),
        .empty    (w_fifoEmpty),
        .count    (w_fifoCount)
    );

    // Fetch PC, response PC and the in-flight bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetchPc     <= RESET_PC;
            r_rspPc       <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (PCSrcE) begin
                r_fetchPc <= w_target;
                r_rspPc   <= w_target;
            end else begin
                if (w_reqFire) r_fetchPc <= r_fetchPc + c_step;
                if (w_keep)    r_rspPc   <= r_rspPc + c_step;
            end

            if (w_reqFire && !w_rspIn)
                r_outstanding <= r_outstanding + CW'(1);
            else if (!w_reqFire && w_rspIn)
                r_outstanding <= r_outstanding - CW'(1);

            // Everything still in flight at a redirect is stale; a response
            // landing in the redirect cycle is already being dropped here.
            if (PCSrcE)
                r_discard <= w_rspIn ? r_outstanding - CW'(1) : r_outstanding;
            else if (ImemRspValid && (r_discard != '0))
                r_discard <= r_discard - CW'(1);
        end
    end

    // IF/ID registers; redirect squashes the slot even while decode stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instrD   <= c_nop;
            r_pcD      <= '0;
            r_pcPlus4D <= '0;
            r_validD   <= 1'b0;
        end else if (PCSrcE) begin
            r_instrD <= c_nop;
            r_validD <= 1'b0;
        end else if (!StallD) begin
            if (!w_fifoEmpty) begin
                r_instrD   <= w_popInstr;
                r_pcD      <= w_popPc;
                r_pcPlus4D <= w_popPc + c_step;
                r_validD   <= 1'b1;
            end else begin
                r_instrD <= c_nop;
                r_validD <= 1'b0;
            end
        end
    end

    assign InstrD   = r_instrD;
    assign PCD      = r_pcD;
    assign PCPlus4D = r_pcPlus4D;
    assign ValidD   = r_validD;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_queue
//  Description : Directed testbench for instruction_fetch_queue with a
//                behavioural instruction memory returning ~addr as the word.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_queue;
    import fetch_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            PCSrcE = 1'b0;
    logic [XLEN-1:0] PCTargetE = '0;
    logic            StallD = 1'b0;
    logic            ImemReqValid;
    logic            ImemReqReady = 1'b0;
    logic [XLEN-1:0] ImemReqAddr;
    logic            ImemRspValid = 1'b0;
    logic [XLEN-1:0] ImemRspData = '0;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;

    int passCnt  = 0;
    int totalCnt = 0;

    bit          randReady = 1'b0;
    int          latMin    = 1;
    int          latMax    = 1;
    int          memCyc    = 0;
    logic [31:0] pendAddr[$];
    int          pendDue[$];

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PCSrcE       (PCSrcE),
        .PCTargetE    (PCTargetE),
        .StallD       (StallD),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemReqAddr  (ImemReqAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD)
    );

    // Instruction memory: acts 3ns after each falling edge, after the
    // stimulus for the coming rising edge has been applied.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            memCyc++;
            if (!rst) begin
                pendAddr.delete();
                pendDue.delete();
                ImemRspValid = 1'b0;
                ImemReqReady = 1'b0;
            end else begin
                if (pendDue.size() > 0 && pendDue[0] <= memCyc) begin
                    ImemRspValid = 1'b1;
                    ImemRspData  = ~pendAddr[0];
                    void'(pendAddr.pop_front());
                    void'(pendDue.pop_front());
                end else begin
                    ImemRspValid = 1'b0;
                end
                ImemReqReady = randReady ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (ImemReqValid && ImemReqReady) begin
                    pendAddr.push_back(ImemReqAddr);
                    pendDue.push_back(memCyc + int'($urandom_range(latMin, latMax)));
                end
            end
        end
    end

    // Observation point: 1ns after the falling edge.
    task automatic obs();
        @(negedge clk);
        #1;
    endtask

    // Returns at the observation point with no rising edge since release.
    task automatic apply_reset();
        PCSrcE = 1'b0;
        StallD = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        totalCnt++; if (ValidD !== 1'b0) $display("FAIL reset_valid: got %b want 0", ValidD); else passCnt++;
        totalCnt++; if (InstrD !== NOP_INSTR) $display("FAIL reset_instr: got %h want %h", InstrD, NOP_INSTR); else passCnt++;
        totalCnt++; if (PCD !== 32'h0) $display("FAIL reset_pcd: got %h want 0", PCD); else passCnt++;
        totalCnt++; if (PCPlus4D !== 32'h0) $display("FAIL reset_pcplus4: got %h want 0", PCPlus4D); else passCnt++;
        totalCnt++; if (ImemReqValid !== 1'b0) $display("FAIL reset_reqvalid: got %b want 0", ImemReqValid); else passCnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_sequence();
        logic [31:0] exp;
        totalCnt++; if (ImemReqValid !== 1'b1) $display("FAIL seq_first_req: got %b want 1", ImemReqValid); else passCnt++;
        totalCnt++; if (ImemReqAddr !== 32'h0) $display("FAIL seq_first_addr: got %h want 0", ImemReqAddr); else passCnt++;
        for (int i = 1; i <= 8; i++) begin
            obs();
            if (i < 3) begin
                totalCnt++; if (ValidD !== 1'b0) $display("FAIL seq_bubble_%0d: got %b want 0", i, ValidD); else passCnt++;
            end else begin
                exp = 32'(4 * (i - 3));
                totalCnt++; if (ValidD !== 1'b1) $display("FAIL seq_valid_%0d: got %b want 1", i, ValidD); else passCnt++;
                totalCnt++; if (PCD !== exp) $display("FAIL seq_pcd_%0d: got %h want %h", i, PCD, exp); else passCnt++;
                totalCnt++; if (PCPlus4D !== exp + 32'd4) $display("FAIL seq_pcplus4_%0d: got %h want %h", i, PCPlus4D, exp + 32'd4); else passCnt++;
                totalCnt++; if (InstrD !== ~exp) $display("FAIL seq_instr_%0d: got %h want %h", i, InstrD, ~exp); else passCnt++;
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        apply_reset();
        for (int i = 1; i <= 3; i++) obs();
        StallD = 1'b1;
        for (int i = 4; i <= 9; i++) begin
            obs();
            totalCnt++; if (ValidD !== 1'b1) $display("FAIL stall_valid_%0d: got %b want 1", i, ValidD); else passCnt++;
            totalCnt++; if (PCD !== 32'h0) $display("FAIL stall_pcd_%0d: got %h want 0", i, PCD); else passCnt++;
            totalCnt++; if (InstrD !== 32'hFFFF_FFFF) $display("FAIL stall_instr_%0d: got %h want ffffffff", i, InstrD); else passCnt++;
            totalCnt++; if (ImemReqValid !== (i < 5)) $display("FAIL stall_reqvalid_%0d: got %b want %b", i, ImemReqValid, (i < 5)); else passCnt++;
        end
        StallD = 1'b0;
        for (int i = 10; i <= 15; i++) begin
            obs();
            exp = 32'(4 * (i - 9));
            totalCnt++; if (ValidD !== 1'b1) $display("FAIL drain_valid_%0d: got %b want 1", i, ValidD); else passCnt++;
            totalCnt++; if (PCD !== exp) $display("FAIL drain_pcd_%0d: got %h want %h", i, PCD, exp); else passCnt++;
        end
    endtask

    task automatic test_redirect();
        latMin = 3;
        latMax = 3;
        apply_reset();
        obs();
        obs();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0103;
        #1;
        totalCnt++; if (ImemReqValid !== 1'b0) $display("FAIL redir_noreq: got %b want 0", ImemReqValid); else passCnt++;
        obs();
        PCSrcE = 1'b0;
        #1;
        totalCnt++; if (ImemReqAddr !== 32'h100) $display("FAIL redir_addr: got %h want 00000100", ImemReqAddr); else passCnt++;
        totalCnt++; if (ValidD !== 1'b0) $display("FAIL redir_edge_valid: got %b want 0", ValidD); else passCnt++;
        for (int i = 4; i <= 7; i++) begin
            obs();
            totalCnt++; if (ValidD !== 1'b0) $display("FAIL redir_drop_%0d: got %b want 0 (pcd %h)", i, ValidD, PCD); else passCnt++;
        end
        obs();
        totalCnt++; if (ValidD !== 1'b1) $display("FAIL redir_valid: got %b want 1", ValidD); else passCnt++;
        totalCnt++; if (PCD !== 32'h100) $display("FAIL redir_pcd: got %h want 00000100", PCD); else passCnt++;
        totalCnt++; if (PCPlus4D !== 32'h104) $display("FAIL redir_pcplus4: got %h want 00000104", PCPlus4D); else passCnt++;
        totalCnt++; if (InstrD !== ~32'h100) $display("FAIL redir_instr: got %h want %h", InstrD, ~32'h100); else passCnt++;
        obs();
        totalCnt++; if (PCD !== 32'h104) $display("FAIL redir_next_pcd: got %h want 00000104", PCD); else passCnt++;
        latMin = 1;
        latMax = 1;
    endtask

    task automatic test_redirect_stall();
        apply_reset();
        for (int i = 1; i <= 3; i++) obs();
        PCSrcE    = 1'b1;
        StallD    = 1'b1;
        PCTargetE = 32'h0000_0200;
        #1;
        totalCnt++; if (ImemReqValid !== 1'b0) $display("FAIL rs_noreq: got %b want 0", ImemReqValid); else passCnt++;
        obs();
        totalCnt++; if (ValidD !== 1'b0) $display("FAIL rs_valid: got %b want 0", ValidD); else passCnt++;
        totalCnt++; if (InstrD !== NOP_INSTR) $display("FAIL rs_instr: got %h want %h", InstrD, NOP_INSTR); else passCnt++;
        PCSrcE = 1'b0;
        StallD = 1'b0;
        #1;
        totalCnt++; if (ImemReqAddr !== 32'h200) $display("FAIL rs_addr: got %h want 00000200", ImemReqAddr); else passCnt++;
        for (int i = 5; i <= 6; i++) begin
            obs();
            totalCnt++; if (ValidD !== 1'b0) $display("FAIL rs_bubble_%0d: got %b want 0 (pcd %h)", i, ValidD, PCD); else passCnt++;
        end
        obs();
        totalCnt++; if (PCD !== 32'h200 || ValidD !== 1'b1) $display("FAIL rs_pcd: got %h/%b want 00000200/1", PCD, ValidD); else passCnt++;
        obs();
        totalCnt++; if (PCD !== 32'h204 || ValidD !== 1'b1) $display("FAIL rs_next_pcd: got %h/%b want 00000204/1", PCD, ValidD); else passCnt++;
    endtask

    task automatic test_random();
        logic [31:0] exp;
        int          got;
        int          cyc;
        randReady = 1'b1;
        latMin    = 1;
        latMax    = 3;
        apply_reset();
        exp = 32'h0;
        got = 0;
        cyc = 0;
        while (got < 200 && cyc < 4000) begin
            obs();
            cyc++;
            if (ValidD === 1'b1) begin
                totalCnt++; if (PCD !== exp) $display("FAIL rand_pcd_%0d: got %h want %h", got, PCD, exp); else passCnt++;
                totalCnt++; if (InstrD !== ~exp) $display("FAIL rand_instr_%0d: got %h want %h", got, InstrD, ~exp); else passCnt++;
                exp = exp + 32'd4;
                got++;
            end
        end
        totalCnt++; if (got != 200) $display("FAIL rand_count: got %0d want 200 within budget", got); else passCnt++;
        randReady = 1'b0;
        latMin    = 1;
        latMax    = 1;
    endtask

    task automatic test_wrap_reset();
        apply_reset();
        for (int i = 1; i <= 3; i++) obs();
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        obs();
        PCSrcE = 1'b0;
        #1;
        totalCnt++; if (ImemReqAddr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", ImemReqAddr); else passCnt++;
        obs();
        totalCnt++; if (ImemReqAddr !== 32'h0) $display("FAIL wrap_addr1: got %h want 00000000", ImemReqAddr); else passCnt++;
        obs();
        obs();
        totalCnt++; if (PCD !== 32'hFFFF_FFFC || ValidD !== 1'b1) $display("FAIL wrap_pcd0: got %h/%b want fffffffc/1", PCD, ValidD); else passCnt++;
        totalCnt++; if (PCPlus4D !== 32'h0) $display("FAIL wrap_pcplus4: got %h want 00000000", PCPlus4D); else passCnt++;
        totalCnt++; if (InstrD !== 32'h3) $display("FAIL wrap_instr: got %h want 00000003", InstrD); else passCnt++;
        obs();
        totalCnt++; if (PCD !== 32'h0 || ValidD !== 1'b1) $display("FAIL wrap_pcd1: got %h/%b want 00000000/1", PCD, ValidD); else passCnt++;
        obs();
        // Asynchronous reset mid-burst, checked before any clock edge.
        rst = 1'b0;
        #1;
        totalCnt++; if (ValidD !== 1'b0) $display("FAIL arst_valid: got %b want 0", ValidD); else passCnt++;
        totalCnt++; if (InstrD !== NOP_INSTR) $display("FAIL arst_instr: got %h want %h", InstrD, NOP_INSTR); else passCnt++;
        totalCnt++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) $display("FAIL arst_pc: got %h/%h want 0/0", PCD, PCPlus4D); else passCnt++;
        totalCnt++; if (ImemReqValid !== 1'b0) $display("FAIL arst_reqvalid: got %b want 0", ImemReqValid); else passCnt++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        totalCnt++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h0) $display("FAIL arst_refetch: got %b/%h want 1/00000000", ImemReqValid, ImemReqAddr); else passCnt++;
        for (int i = 1; i <= 3; i++) obs();
        totalCnt++; if (PCD !== 32'h0 || ValidD !== 1'b1) $display("FAIL arst_first: got %h/%b want 00000000/1", PCD, ValidD); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_random();
        test_wrap_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire
